// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared constants and width helper for the round-robin mux arbiter
package rr_mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Select width never drops below one bit so a 2-way (or degenerate) mux still has an index port.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_grant.sv
// rtl/rr_mux_arbiter_grant.sv - combinational round-robin / fixed-priority grant for N requesters
module rr_grant
    import rr_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mode,
    output logic             grant_vld,
    output logic [SEL_W-1:0] grant_idx
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

    logic [SEL_W-1:0] scan_idx;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = ptr;
        if (mode) begin
            // Ascending scan lets the highest requesting index overwrite lower ones.
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // Walk ptr, ptr+1, ... with an explicit wrap so non-power-of-2 N never overflows.
            for (int k = 0; k < N; k++) begin
                if (!grant_vld && req[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                end
                scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - N-way arbitrated channel selector with one-entry registered output stage
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int MODE  = MODE_RR,
    parameter int SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             force_en,
    input  logic [SEL_W-1:0] force_sel,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int               PAD_N    = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);
    localparam logic             MODE_BIT = (MODE == MODE_FIXED);

    logic [W-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    logic             arb_vld;
    logic [SEL_W-1:0] arb_idx;
    logic [PAD_N-1:0] valid_pad;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             load_en;
    logic             transfer;
    logic [W-1:0]     sel_data;

    rr_grant #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_grant (
        .req       (in_valid),
        .ptr       (ptr_q),
        .mode      (MODE_BIT),
        .grant_vld (arb_vld),
        .grant_idx (arb_idx)
    );

    // Zero-padding makes an out-of-range force_sel read as "not valid" instead of indexing past N.
    assign valid_pad = PAD_N'(in_valid);
    assign load_en   = !out_valid_q || out_ready;

    always_comb begin
        grant_vld = force_en ? valid_pad[force_sel] : arb_vld;
        grant_idx = force_en ? force_sel : arb_idx;
        transfer  = !rst && load_en && grant_vld;
        in_ready  = '0;
        if (transfer) begin
            in_ready = N'(1) << grant_idx;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                sel_data = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (transfer) begin
            out_data_d  = sel_data;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            if (!MODE_BIT) begin
                ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (MODE_BIT) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
